radix_reverse: RTL and testbench

RADIX_REVERSE -- requirements
Module: radix_reverse

---
 rtl/radix_reverse_pkg.sv | 22 ++
 rtl/radix_reverse_if.sv | 31 +++
 rtl/radix_reverse_digit_step.sv | 29 ++
 rtl/radix_reverse.sv | 101 ++++++++++
 tb/tb_radix_reverse.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/radix_reverse_pkg.sv
// Shared definitions for the radix digit-reversal block: controller states
// and the legal parameter ranges checked at elaboration.
package radix_reverse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 32;
  localparam int RADIX_MIN = 2;
  localparam int RADIX_MAX = 16;

  // True when a WIDTH/RADIX pair lies inside the supported range.
  function automatic bit params_legal(input int width, input int radix);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           (radix >= RADIX_MIN) && (radix <= RADIX_MAX);
  endfunction

endpackage

// File: rtl/radix_reverse_if.sv
// Request/result bundle for radix_reverse.
//
// Handshake: the requester holds start=1 with x stable; the request is taken
// on the rising edge where ready=1 and start=1. ready is high only while the
// block is idle, so start at any other time has no effect and is not queued.
// Completion is a single-cycle done pulse; reverse/digits/ovf/palin are
// updated on the edge that raises done and hold until the next completion.
interface radix_reverse_if #(
  parameter int WIDTH = 16
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] x;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] reverse;
  logic [CW-1:0]    digits;
  logic             ovf;
  logic             palin;

  modport master (
    output start, x,
    input  ready, done, reverse, digits, ovf, palin
  );

  modport slave (
    input  start, x,
    output ready, done, reverse, digits, ovf, palin
  );
endinterface

// File: rtl/radix_reverse_digit_step.sv
// One digit of the reversal: peel the least-significant RADIX digit off x,
// append it to the partial reverse, and flag when the append no longer fits
// in WIDTH bits. RE*RADIX+digit is formed 4 bits wider than WIDTH, which is
// enough because RADIX <= 16 and the digit is below RADIX.
module digit_step #(
  parameter int WIDTH = 16,
  parameter int RADIX = 10
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] re,
  output logic [WIDTH-1:0] x_div,
  output logic [WIDTH-1:0] re_next,
  output logic             ovf_step
);
  localparam logic [WIDTH-1:0] RADIX_N = WIDTH'(RADIX);
  localparam logic [WIDTH+3:0] RADIX_E = (WIDTH + 4)'(RADIX);

  logic [WIDTH-1:0] digit;
  logic [WIDTH+3:0] acc;

  // Divide/modulo by the radix and the widened multiply-add.
  always_comb begin
    digit    = x % RADIX_N;
    x_div    = x / RADIX_N;
    acc      = {4'b0000, re} * RADIX_E + {4'b0000, digit};
    re_next  = acc[WIDTH-1:0];
    ovf_step = |acc[WIDTH+3:WIDTH];
  end
endmodule

// File: rtl/radix_reverse.sv
// Iterative radix digit reversal: one digit per clock, results published
// together on completion so the outputs never show partial values.
module radix_reverse
  import radix_reverse_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int RADIX = 10
) (
  input  logic               clk,
  input  logic               rst,
  radix_reverse_if.slave     bus,
  output state_t             dbg_state
);
  localparam int CW = $clog2(WIDTH + 1);

  if (!params_legal(WIDTH, RADIX)) begin : g_param_check
    $error("radix_reverse: WIDTH %0d or RADIX %0d out of range", WIDTH, RADIX);
  end

  state_t           state_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] orig_q;
  logic [WIDTH-1:0] re_q;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q;

  logic [WIDTH-1:0] x_div;
  logic [WIDTH-1:0] re_next;
  logic             ovf_step;

  digit_step #(
    .WIDTH(WIDTH),
    .RADIX(RADIX)
  ) u_step (
    .x        (x_q),
    .re       (re_q),
    .x_div    (x_div),
    .re_next  (re_next),
    .ovf_step (ovf_step)
  );

  assign dbg_state = state_q;

  // Controller: capture, iterate until x is exhausted, publish, pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      orig_q      <= '0;
      re_q        <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      bus.ready   <= 1'b1;
      bus.done    <= 1'b0;
      bus.reverse <= '0;
      bus.digits  <= '0;
      bus.ovf     <= 1'b0;
      bus.palin   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            x_q       <= bus.x;
            orig_q    <= bus.x;
            re_q      <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            bus.ready <= 1'b0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (x_q != '0) begin
            re_q  <= re_next;
            x_q   <= x_div;
            cnt_q <= cnt_q + CW'(1);
            ovf_q <= ovf_q | ovf_step;
          end else begin
            bus.reverse <= re_q;
            bus.digits  <= cnt_q;
            bus.ovf     <= ovf_q;
            bus.palin   <= (re_q == orig_q) && !ovf_q;
            bus.done    <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          bus.done  <= 1'b0;
          bus.ready <= 1'b1;
          state_q   <= IDLE;
        end
        default: begin
          bus.done  <= 1'b0;
          bus.ready <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_radix_reverse.sv
// Bench for radix_reverse: three instances (radix 10, 2 and 16, all 16 bits)
// driven by directed and random operands, checked against a digit-list model.
module tb_radix_reverse;
  import radix_reverse_pkg::*;

  localparam int W  = 16;
  localparam int CW = $clog2(W + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  radix_reverse_if #(.WIDTH(W)) if_r10 ();
  radix_reverse_if #(.WIDTH(W)) if_r2 ();
  radix_reverse_if #(.WIDTH(W)) if_r16 ();
  state_t st_o [3];

  radix_reverse #(.WIDTH(W), .RADIX(10)) u_r10 (.clk(clk), .rst(rst), .bus(if_r10), .dbg_state(st_o[0]));
  radix_reverse #(.WIDTH(W), .RADIX(2))  u_r2  (.clk(clk), .rst(rst), .bus(if_r2),  .dbg_state(st_o[1]));
  radix_reverse #(.WIDTH(W), .RADIX(16)) u_r16 (.clk(clk), .rst(rst), .bus(if_r16), .dbg_state(st_o[2]));

  logic          start_v [3];
  logic [W-1:0]  x_v     [3];
  logic          ready_o [3];
  logic          done_o  [3];
  logic          ovf_o   [3];
  logic          palin_o [3];
  logic [W-1:0]  rev_o   [3];
  logic [CW-1:0] dig_o   [3];

  assign if_r10.start = start_v[0];
  assign if_r10.x     = x_v[0];
  assign if_r2.start  = start_v[1];
  assign if_r2.x      = x_v[1];
  assign if_r16.start = start_v[2];
  assign if_r16.x     = x_v[2];

  assign ready_o[0] = if_r10.ready;  assign ready_o[1] = if_r2.ready;  assign ready_o[2] = if_r16.ready;
  assign done_o[0]  = if_r10.done;   assign done_o[1]  = if_r2.done;   assign done_o[2]  = if_r16.done;
  assign ovf_o[0]   = if_r10.ovf;    assign ovf_o[1]   = if_r2.ovf;    assign ovf_o[2]   = if_r16.ovf;
  assign palin_o[0] = if_r10.palin;  assign palin_o[1] = if_r2.palin;  assign palin_o[2] = if_r16.palin;
  assign rev_o[0]   = if_r10.reverse; assign rev_o[1]  = if_r2.reverse; assign rev_o[2]  = if_r16.reverse;
  assign dig_o[0]   = if_r10.digits; assign dig_o[1]   = if_r2.digits; assign dig_o[2]   = if_r16.digits;

  int radix_of [3] = '{10, 2, 16};

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: write x as a list of digits (most significant first), read the
  // list backwards as a number. Overflow means that number exceeds W bits.
  function automatic void model(input int radix, input logic [W-1:0] xv,
                                output logic [W-1:0] rev, output int nd,
                                output logic ov, output logic pal);
    int     digs[$];
    longint v;
    longint full;
    v = longint'(xv);
    while (v != 0) begin
      digs.push_front(int'(v % radix));
      v = v / radix;
    end
    digs.reverse();
    full = 0;
    foreach (digs[i]) full = full * radix + digs[i];
    nd  = digs.size();
    ov  = full > ((longint'(1) << W) - 1);
    rev = W'(full);
    pal = (full == longint'(xv));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int sel);
    int n = 0;
    while (ready_o[sel] !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_ready", ready_o[sel], 1'b1);
  endtask

  task automatic run_op(input int sel, input logic [W-1:0] xv);
    logic [W-1:0] erev;
    logic [W-1:0] prev;
    logic [W-1:0] got;
    int           nd;
    logic         eov;
    logic         epal;
    int           n;
    bit           seen;
    model(radix_of[sel], xv, erev, nd, eov, epal);
    exp_q.push_back(erev);
    wait_ready(sel);
    prev         = rev_o[sel];
    start_v[sel] = 1'b1;
    x_v[sel]     = xv;
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    x_v[sel]     = W'($urandom);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done_o[sel] === 1'b1) seen = 1'b1;
      else check("hold_reverse", rev_o[sel], prev);
    end
    got = exp_q.pop_front();
    check("done_seen", seen, 1'b1);
    if (seen) begin
      check("latency", n, nd + 1);
      check("reverse", rev_o[sel], got);
      check("digits", dig_o[sel], nd);
      check("ovf", ovf_o[sel], eov);
      check("palin", palin_o[sel], epal);
      @(posedge clk); #1;
      check("done_one_cycle", done_o[sel], 1'b0);
      check("ready_after_done", ready_o[sel], 1'b1);
    end
  endtask

  task automatic check_reset_outputs(input int sel);
    check("rst_ready", ready_o[sel], 1'b1);
    check("rst_done", done_o[sel], 1'b0);
    check("rst_reverse", rev_o[sel], 0);
    check("rst_digits", dig_o[sel], 0);
    check("rst_ovf", ovf_o[sel], 1'b0);
    check("rst_palin", palin_o[sel], 1'b0);
    check("rst_state", st_o[sel], IDLE);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    int dones;
    bit seen;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      x_v[i]     = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) check_reset_outputs(i);

    // Directed operands
    run_op(0, 16'd1234);
    run_op(0, 16'd0);
    run_op(0, 16'd12321);
    run_op(0, 16'd60009);
    run_op(0, 16'd120);
    run_op(0, 16'd65535);
    run_op(1, 16'd6);
    run_op(2, 16'h1234);
    run_op(2, 16'h0000);

    // start held high: x changes mid-run must be ignored; the next accept
    // happens only after returning to idle and picks up the new x.
    wait_ready(0);
    start_v[0] = 1'b1;
    x_v[0]     = 16'd1234;
    @(posedge clk); #1;
    x_v[0] = 16'd56;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1; n++;
      if (done_o[0] === 1'b1) seen = 1'b1;
    end
    check("held_done_seen", seen, 1'b1);
    check("held_latency", n, 5);
    check("held_reverse", rev_o[0], 16'd4321);
    @(posedge clk); #1;
    check("held_idle_ready", ready_o[0], 1'b1);
    check("held_idle_done", done_o[0], 1'b0);
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1; n++;
      if (done_o[0] === 1'b1) seen = 1'b1;
    end
    start_v[0] = 1'b0;
    check("held_second_latency", n, 4);
    check("held_second_reverse", rev_o[0], 16'd65);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("held_back_idle", ready_o[0], 1'b1);

    // Reset two cycles into a run, with start also high on the reset edge.
    wait_ready(0);
    start_v[0] = 1'b1;
    x_v[0]     = 16'd1234;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst        = 1'b1;
    start_v[0] = 1'b1;
    x_v[0]     = 16'd9;
    @(posedge clk); #1;
    rst        = 1'b0;
    start_v[0] = 1'b0;
    check_reset_outputs(0);
    dones = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done_o[0] === 1'b1) dones++;
    end
    check("no_done_after_rst", dones, 0);
    run_op(0, 16'd56);

    // Random operands
    repeat (15) run_op(0, W'($urandom_range(0, 65535)));
    repeat (4)  run_op(1, W'($urandom_range(0, 65535)));
    repeat (4)  run_op(2, W'($urandom_range(0, 65535)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
